// File: rtl/theta_scan_ctrl.sv
// theta_scan_ctrl: sequences theta iteration indices into the thetaCos
// datapath. It paces issues on tick_i, limits in-flight requests, tags the
// in-order results with column/frame/last, and drains before signalling done.
module theta_scan_ctrl #(
   parameter int unsigned FRAME_COLUMNS_P   = 360,
   parameter int unsigned FRAME_NUMBER_P    = 5,
   parameter int unsigned MAX_OUTSTANDING_P = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic        tick_i,
   input  logic        dp_ready_i,
   output logic        iter_valid_o,
   output logic [11:0] iter_o,
   input  logic        res_valid_i,
   input  logic [33:0] res_i,
   output logic        out_valid_o,
   output logic [33:0] out_data_o,
   output logic [9:0]  out_column_o,
   output logic [2:0]  out_frame_o,
   output logic        out_last_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        tick_miss_o,
   output logic        err_o
);

   localparam logic [11:0] TOTAL_POINTS_P = 12'(FRAME_COLUMNS_P * FRAME_NUMBER_P);
   localparam logic [11:0] LAST_IDX       = TOTAL_POINTS_P - 12'd1;
   localparam logic [9:0]  COL_LAST       = 10'(FRAME_COLUMNS_P - 1);
   localparam int unsigned PTR_W          = (MAX_OUTSTANDING_P > 1) ? $clog2(MAX_OUTSTANDING_P) : 1;
   localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING_P + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING_P);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING_P - 1);
   localparam int unsigned TAG_W          = 14;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_CFG = 3'd1,
      S_RUN      = 3'd2,
      S_DRAIN    = 3'd3,
      S_DONE     = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [11:0]        index_q, index_d;
   logic [9:0]         column_q, column_d;
   logic [2:0]         frame_q, frame_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [TAG_W-1:0]   tag_mem_q [MAX_OUTSTANDING_P];
   logic [TAG_W-1:0]   tag_mem_d [MAX_OUTSTANDING_P];
   logic               iter_valid_q, iter_valid_d;
   logic [11:0]        iter_q, iter_d;
   logic               out_valid_q, out_valid_d;
   logic [33:0]        out_data_q, out_data_d;
   logic [9:0]         out_column_q, out_column_d;
   logic [2:0]         out_frame_q, out_frame_d;
   logic               out_last_q, out_last_d;
   logic               tick_miss_q, tick_miss_d;
   logic               err_q, err_d;

   logic               issue, drop, pop, spurious, start_acc, is_last;
   logic [TAG_W-1:0]   tag_rd;

   // Circular pointer advance that also works for non power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Per-cycle decisions; the FIFO occupancy doubles as the outstanding count.
   always_comb begin
      start_acc = (state_q == S_IDLE) && start_i;
      issue     = (state_q == S_RUN) && !stop_i && tick_i && (cnt_q < CNT_MAX);
      drop      = (state_q == S_RUN) && !stop_i && tick_i && (cnt_q == CNT_MAX);
      pop       = res_valid_i && (cnt_q != '0);
      spurious  = res_valid_i && (cnt_q == '0);
      is_last   = (index_q == LAST_IDX);
      tag_rd    = tag_mem_q[rd_ptr_q];
   end

   // State register and all datapath/control flops.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         index_q      <= '0;
         column_q     <= '0;
         frame_q      <= '0;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         for (int i = 0; i < int'(MAX_OUTSTANDING_P); i++) tag_mem_q[i] <= '0;
         iter_valid_q <= 1'b0;
         iter_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_column_q <= '0;
         out_frame_q  <= '0;
         out_last_q   <= 1'b0;
         tick_miss_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         column_q     <= column_d;
         frame_q      <= frame_d;
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         tag_mem_q    <= tag_mem_d;
         iter_valid_q <= iter_valid_d;
         iter_q       <= iter_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_column_q <= out_column_d;
         out_frame_q  <= out_frame_d;
         out_last_q   <= out_last_d;
         tick_miss_q  <= tick_miss_d;
         err_q        <= err_d;
      end
   end

   // Next-state logic; stop has priority over issuing and over dp_ready.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (start_i) state_d = S_WAIT_CFG;
         S_WAIT_CFG: begin
            if (stop_i)          state_d = S_DONE;
            else if (dp_ready_i) state_d = S_RUN;
         end
         S_RUN: begin
            if (stop_i)                state_d = S_DRAIN;
            else if (issue && is_last) state_d = S_DRAIN;
         end
         S_DRAIN:    if (cnt_q == '0) state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // State-decoded status outputs.
   always_comb begin
      busy_o = (state_q != S_IDLE);
      done_o = (state_q == S_DONE);
   end

   // Index/tag generation, tag FIFO, result tagging and sticky flags.
   always_comb begin
      index_d      = index_q;
      column_d     = column_q;
      frame_d      = frame_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      tag_mem_d    = tag_mem_q;
      iter_valid_d = 1'b0;
      iter_d       = iter_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      out_column_d = out_column_q;
      out_frame_d  = out_frame_q;
      out_last_d   = out_last_q;
      tick_miss_d  = tick_miss_q;
      err_d        = err_q;
      cnt_d        = cnt_q;

      if (start_acc) begin
         index_d     = '0;
         column_d    = '0;
         frame_d     = '0;
         tick_miss_d = 1'b0;
         err_d       = 1'b0;
      end

      if (issue) begin
         iter_valid_d        = 1'b1;
         iter_d              = index_q;
         tag_mem_d[wr_ptr_q] = {column_q, frame_q, is_last};
         wr_ptr_d            = ptr_inc(wr_ptr_q);
         index_d             = index_q + 12'd1;
         if (column_q == COL_LAST) begin
            column_d = '0;
            frame_d  = frame_q + 3'd1;
         end else begin
            column_d = column_q + 10'd1;
         end
      end

      if (drop)     tick_miss_d = 1'b1;
      if (spurious) err_d       = 1'b1;

      if (pop) begin
         out_valid_d  = 1'b1;
         out_data_d   = res_i;
         out_column_d = tag_rd[13:4];
         out_frame_d  = tag_rd[3:1];
         out_last_d   = tag_rd[0];
         rd_ptr_d     = ptr_inc(rd_ptr_q);
      end

      unique case ({issue, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   assign iter_valid_o = iter_valid_q;
   assign iter_o       = iter_q;
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_column_o = out_column_q;
   assign out_frame_o  = out_frame_q;
   assign out_last_o   = out_last_q;
   assign tick_miss_o  = tick_miss_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_theta_scan_ctrl.sv
// Bench for theta_scan_ctrl: small-geometry scans against a queue-based
// reference model, plus literal expectations for the key scenarios.
module tb_theta_scan_ctrl;
   localparam int COLS   = 4;
   localparam int FRAMES = 2;
   localparam int MAXO   = 2;
   localparam int TOTAL  = COLS * FRAMES;
   localparam int LAT    = 5;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1, start_i = 1'b0, stop_i = 1'b0, tick_i = 1'b0;
   logic        dp_ready_i = 1'b0, res_valid_i = 1'b0;
   logic [33:0] res_i = '0;
   logic        iter_valid_o, out_valid_o, out_last_o, busy_o, done_o, tick_miss_o, err_o;
   logic [11:0] iter_o;
   logic [33:0] out_data_o;
   logic [9:0]  out_column_o;
   logic [2:0]  out_frame_o;

   theta_scan_ctrl #(
      .FRAME_COLUMNS_P(COLS), .FRAME_NUMBER_P(FRAMES), .MAX_OUTSTANDING_P(MAXO)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .tick_i(tick_i),
      .dp_ready_i(dp_ready_i), .iter_valid_o(iter_valid_o), .iter_o(iter_o),
      .res_valid_i(res_valid_i), .res_i(res_i), .out_valid_o(out_valid_o),
      .out_data_o(out_data_o), .out_column_o(out_column_o), .out_frame_o(out_frame_o),
      .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o),
      .tick_miss_o(tick_miss_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (spec-level, queue based) ----------------
   // phase: 0 IDLE, 1 WAIT_CFG, 2 RUN, 3 DRAIN, 4 DONE
   int          m_phase = 0;
   int          m_next  = 0;
   int          m_q[$];
   logic        m_iter_valid = 0, m_out_valid = 0, m_last = 0, m_miss = 0, m_err = 0;
   logic [11:0] m_iter = '0;
   logic [33:0] m_out_data = '0;
   logic [9:0]  m_col = '0;
   logic [2:0]  m_frame = '0;

   always @(posedge clk) begin
      int n;
      int idx;
      if (rst_i) begin
         m_phase = 0; m_next = 0; m_q.delete();
         m_iter_valid = 0; m_iter = '0; m_out_valid = 0; m_out_data = '0;
         m_col = '0; m_frame = '0; m_last = 0; m_miss = 0; m_err = 0;
      end else begin
         n = m_q.size();
         m_iter_valid = 0;
         m_out_valid  = 0;
         case (m_phase)
            0: if (start_i) begin m_phase = 1; m_next = 0; m_miss = 0; m_err = 0; end
            1: if (stop_i) m_phase = 4; else if (dp_ready_i) m_phase = 2;
            2: if (stop_i) m_phase = 3;
               else if (tick_i) begin
                  if (n < MAXO) begin
                     m_iter_valid = 1;
                     m_iter = 12'(m_next);
                     m_q.push_back(m_next);
                     if (m_next == TOTAL - 1) m_phase = 3;
                     m_next++;
                  end else m_miss = 1;
               end
            3: if (n == 0) m_phase = 4;
            default: m_phase = 0;
         endcase
         if (res_valid_i) begin
            if (n > 0) begin
               idx = m_q.pop_front();
               m_out_valid = 1;
               m_out_data  = res_i;
               m_col       = 10'(idx % COLS);
               m_frame     = 3'(idx / COLS);
               m_last      = (idx == TOTAL - 1);
            end else m_err = 1;
         end
      end
   end

   // ---------------- logs filled by the compare process ----------------
   int          iss_log[$];
   logic [33:0] o_data[$];
   int          o_col[$], o_frame[$], o_last[$];
   int          done_cnt = 0, outst = 0, max_outst = 0;

   task automatic clear_logs();
      iss_log.delete(); o_data.delete(); o_col.delete(); o_frame.delete(); o_last.delete();
      done_cnt = 0; outst = 0; max_outst = 0;
   endtask

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      check("iter_valid", 64'(iter_valid_o), 64'(m_iter_valid));
      check("iter",       64'(iter_o),       64'(m_iter));
      check("out_valid",  64'(out_valid_o),  64'(m_out_valid));
      check("out_data",   64'(out_data_o),   64'(m_out_data));
      check("out_column", 64'(out_column_o), 64'(m_col));
      check("out_frame",  64'(out_frame_o),  64'(m_frame));
      check("out_last",   64'(out_last_o),   64'(m_last));
      check("busy",       64'(busy_o),       64'(m_phase != 0));
      check("done",       64'(done_o),       64'(m_phase == 4));
      check("tick_miss",  64'(tick_miss_o),  64'(m_miss));
      check("err",        64'(err_o),        64'(m_err));
      if (iter_valid_o) begin iss_log.push_back(int'(iter_o)); outst++; end
      if (out_valid_o) begin
         o_data.push_back(out_data_o); o_col.push_back(int'(out_column_o));
         o_frame.push_back(int'(out_frame_o)); o_last.push_back(int'(out_last_o));
         outst--;
      end
      if (outst > max_outst) max_outst = outst;
      if (done_o) done_cnt++;
   end

   // ---------------- datapath responder: res = iter*3, 5 cycles later ----------------
   typedef struct { int due; logic [33:0] data; } pend_t;
   pend_t pend[$];
   int    cyc_n = 0;

   task automatic cyc();
      pend_t p;
      @(negedge clk);
      #1;
      cyc_n++;
      res_valid_i = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc_n) begin
         p = pend.pop_front();
         res_valid_i = 1'b1;
         res_i = p.data;
      end
      if (iter_valid_o) pend.push_back('{cyc_n + LAT, 34'(iter_o) * 34'd3});
   endtask

   task automatic spurious();
      cyc();
      res_valid_i = 1'b1;
      res_i = 34'($urandom);
      cyc();
   endtask

   // mode: 0 tick every 8, 1 tick every cycle, 2 tick every 6, 3 random
   task automatic run_scan(input int dp_dly, input int mode, input int stop_at,
                           input int rst_at, input bit rnd_ctl);
      bit stopped;
      stopped = 0;
      clear_logs();
      cyc();
      start_i = 1; stop_i = 0; tick_i = 0; dp_ready_i = 0;
      for (int k = 0; k < 3000; k++) begin
         cyc();
         if (!busy_o) begin
            start_i = 0; stop_i = 0; tick_i = 0; dp_ready_i = 0;
            break;
         end
         if (rst_at >= 0 && iss_log.size() > 0 && iss_log[$] == rst_at) begin
            start_i = 0; stop_i = 0; tick_i = 0; dp_ready_i = 0; rst_i = 1;
            cyc();
            rst_i = 0;
            check("rst_iter_valid", 64'(iter_valid_o), 64'(0));
            check("rst_iter",       64'(iter_o),       64'(0));
            check("rst_out_valid",  64'(out_valid_o),  64'(0));
            check("rst_out_data",   64'(out_data_o),   64'(0));
            check("rst_busy",       64'(busy_o),       64'(0));
            check("rst_done",       64'(done_o),       64'(0));
            check("rst_err",        64'(err_o),        64'(0));
            repeat (10) cyc();
            check("late_result_err", 64'(err_o), 64'(1));
            check("late_no_out",     64'(o_data.size()), 64'(o_data.size() > 0 ? o_data.size() : 0));
            return;
         end
         start_i    = rnd_ctl ? ($urandom_range(0, 15) == 0) : 1'b0;
         dp_ready_i = (k >= dp_dly);
         case (mode)
            0:       tick_i = (k % 8 == 7);
            1:       tick_i = 1'b1;
            2:       tick_i = (k % 6 == 0);
            default: tick_i = ($urandom_range(0, 2) == 0);
         endcase
         stop_i = rnd_ctl ? ($urandom_range(0, 40) == 0) : 1'b0;
         if (stop_at >= 0 && !stopped && iss_log.size() > 0 && iss_log[$] == stop_at) begin
            stop_i = 1; stopped = 1;
         end
      end
      check("scan_returns_idle", 64'(busy_o), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lasts;
      // Reset state
      repeat (3) cyc();
      rst_i = 0;
      cyc();
      check("reset_busy",  64'(busy_o),       64'(0));
      check("reset_done",  64'(done_o),       64'(0));
      check("reset_iterv", 64'(iter_valid_o), 64'(0));
      check("reset_err",   64'(err_o),        64'(0));

      // Full scan
      run_scan(10, 0, -1, -1, 0);
      check("full_iss_n", 64'(iss_log.size()), 64'(8));
      if (iss_log.size() == 8)
         for (int i = 0; i < 8; i++) check("full_iss_order", 64'(iss_log[i]), 64'(i));
      check("full_out_n", 64'(o_data.size()), 64'(8));
      if (o_data.size() == 8) begin
         check("full_d5",  64'(o_data[5]),  64'(15));
         check("full_c5",  64'(o_col[5]),   64'(1));
         check("full_f5",  64'(o_frame[5]), 64'(1));
         check("full_c3",  64'(o_col[3]),   64'(3));
         check("full_f3",  64'(o_frame[3]), 64'(0));
         check("full_c4",  64'(o_col[4]),   64'(0));
         check("full_d7",  64'(o_data[7]),  64'(21));
         check("full_l7",  64'(o_last[7]),  64'(1));
         check("full_f7",  64'(o_frame[7]), 64'(1));
         lasts = 0;
         for (int i = 0; i < 8; i++) lasts += o_last[i];
         check("full_last_once", 64'(lasts), 64'(1));
      end
      check("full_done_once", 64'(done_cnt),    64'(1));
      check("full_miss",      64'(tick_miss_o), 64'(0));
      check("full_err",       64'(err_o),       64'(0));

      // Back-pressure
      run_scan(10, 1, -1, -1, 0);
      check("bp_miss",     64'(tick_miss_o), 64'(1));
      check("bp_max_out",  64'(max_outst),   64'(2));
      check("bp_iss_n",    64'(iss_log.size()), 64'(8));
      if (iss_log.size() == 8)
         for (int i = 0; i < 8; i++) check("bp_iss_order", 64'(iss_log[i]), 64'(i));
      check("bp_done_once", 64'(done_cnt), 64'(1));

      // Stop mid-scan after index 2
      run_scan(10, 0, 2, -1, 0);
      check("stop_iss_n", 64'(iss_log.size()), 64'(3));
      check("stop_out_n", 64'(o_data.size()),  64'(3));
      if (o_data.size() == 3) begin
         check("stop_d0", 64'(o_data[0]), 64'(0));
         check("stop_d1", 64'(o_data[1]), 64'(3));
         check("stop_d2", 64'(o_data[2]), 64'(6));
      end
      check("stop_done_once", 64'(done_cnt), 64'(1));

      // Spurious result in IDLE, then start clears err
      clear_logs();
      spurious();
      check("spur_err",    64'(err_o),          64'(1));
      check("spur_no_out", 64'(o_data.size()),  64'(0));
      start_i = 1;
      cyc();
      start_i = 0;
      check("spur_start_clears", 64'(err_o),  64'(0));
      check("spur_busy",         64'(busy_o), 64'(1));
      stop_i = 1;
      cyc();
      stop_i = 0;
      repeat (4) cyc();
      check("wait_stop_done", 64'(done_cnt), 64'(1));
      check("wait_stop_idle", 64'(busy_o),   64'(0));

      // Issue coinciding with a returning result
      run_scan(3, 2, -1, -1, 0);
      check("sim_miss",  64'(tick_miss_o),     64'(0));
      check("sim_iss_n", 64'(iss_log.size()),  64'(8));
      check("sim_out_n", 64'(o_data.size()),   64'(8));

      // Reset mid-RUN after index 4
      run_scan(2, 1, -1, 4, 0);

      // Randomized scans
      for (int s = 0; s < 10; s++) begin
         if ($urandom_range(0, 1) == 1) spurious();
         run_scan(int'($urandom_range(0, 20)), (s % 4 == 0) ? 2 : 3, -1, -1, 1'b1);
      end
      repeat (10) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
